// File: rtl/gcd_pkg.sv
// Shared types for the GCD requester: FSM state encoding and default datapath width.
package gcd_pkg;

  localparam int GCD_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GUARD,
    WAIT,
    RESP
  } gcd_state_e;

endpackage

// File: rtl/gcd_req_fifo.sv
// Request queue for the GCD requester: DEPTH-entry FIFO (DEPTH a power of 2, >= 2).
// The head entry is visible on dout whenever the queue is not empty.
module gcd_req_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          push_ok, pop_ok;

  // Pushing into a full queue is ignored even if a pop happens the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign dout    = mem[rp];

  // Storage array; contents need no reset since occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop_ok)  rp <= rp + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/gcd_requester.sv
// GCD requester: queues operand pairs, issues them one at a time to a
// subtraction GCD engine, and returns one response (result or error) per job.
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 65544
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_a,
  output logic [WIDTH-1:0] gcd_b,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  localparam int            CW    = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  gcd_state_e         state, nxt;
  logic [2*WIDTH-1:0] head;
  logic               full, empty, pop;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [CW-1:0]      tcnt;
  logic               op_nz, tmo;

  gcd_req_fifo #(
    .W    (2*WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (req_valid && req_ready),
    .din  ({req_a, req_b}),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  assign req_ready = !full;
  assign busy      = !empty || (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign gcd_a     = op_a;
  assign gcd_b     = op_b;
  assign op_nz     = (|op_a) && (|op_b);
  // Counter runs from GUARD, so hitting TLAST means TIMEOUT engine cycles used.
  assign tmo       = (tcnt == TLAST);

  // Next-state and strobes; gcd_done is only looked at in WAIT so a done
  // left over from a previous job cannot complete the new one.
  always_comb begin
    nxt       = state;
    pop       = 1'b0;
    gcd_start = 1'b0;
    case (state)
      IDLE:  if (!empty) begin pop = 1'b1; nxt = ISSUE; end
      ISSUE: begin
        if (op_nz) begin gcd_start = 1'b1; nxt = GUARD; end
        else nxt = RESP;
      end
      GUARD: nxt = WAIT;
      WAIT:  if (gcd_done || tmo) nxt = RESP;
      RESP:  if (rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Job datapath: operand capture, timeout counter, response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      tcnt     <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (pop) {op_a, op_b} <= head;
      case (state)
        ISSUE: begin
          tcnt <= '0;
          if (!op_nz) begin
            rsp_data <= op_a | op_b;
            rsp_err  <= !(|op_a) && !(|op_b);
          end
        end
        GUARD: tcnt <= tcnt + CW'(1);
        WAIT: begin
          if (gcd_done) begin
            rsp_data <= gcd_result;
            rsp_err  <= 1'b0;
          end else if (tmo) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester with a small behavioural GCD engine.
module tb_gcd_requester;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int TO = 20;

  logic         clk = 0, rst_n = 1;
  logic         req_valid = 0, req_ready;
  logic [W-1:0] req_a = 0, req_b = 0;
  logic         gcd_start, gcd_done;
  logic [W-1:0] gcd_a, gcd_b, gcd_result;
  logic         rsp_valid, rsp_ready = 1, rsp_err, busy;
  logic [W-1:0] rsp_data;

  int passed = 0, total = 0;
  int cyc = 0, starts = 0, done_cyc = -1;

  // engine model controls
  logic         eng_done = 0, eng_hang = 0, stale_done = 0, done_q = 0;
  int           eng_cnt = 0, eng_delay = 5;
  logic [W-1:0] eng_res = 0, stale_val = 0;

  assign gcd_done   = eng_done | stale_done;
  assign gcd_result = stale_done ? stale_val : eng_res;

  gcd_requester #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_done(gcd_done), .gcd_result(gcd_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gcd_fn(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // Engine: done is sticky until the next start, raised eng_delay cycles after start.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (gcd_start) begin
      starts   <= starts + 1;
      eng_done <= 1'b0;
      eng_cnt  <= eng_delay;
      eng_res  <= gcd_fn(gcd_a, gcd_b);
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1 && !eng_hang) eng_done <= 1'b1;
    end
  end

  always @(negedge clk) begin
    done_q <= gcd_done;
    if (gcd_done && !done_q) done_cyc <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Called at a negedge; leaves at the negedge after the push edge.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, output logic acc);
    req_valid = 1; req_a = a; req_b = b;
    acc = req_ready;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wait_rsp(output int c, output logic [W-1:0] d, output logic e);
    logic seen;
    seen = 0; c = -1; d = '0; e = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1; c = cyc; d = rsp_data; e = rsp_err; end
    end
    if (!seen) chk("rsp_timeout", 0, 1);
  endtask

  task automatic wait_start(output int c);
    logic seen;
    seen = 0; c = -1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (gcd_start) begin seen = 1; c = cyc; end
    end
    if (!seen) chk("start_timeout", 0, 1);
  endtask

  initial begin
    int n, c, r, s0, nacc, nrsp, nst;
    logic acc, e;
    logic [W-1:0] d;

    // ---- reset state
    #3 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gcd_start", gcd_start, 0);
    chk("rst_gcd_a", gcd_a, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // ---- zero-operand jobs: (0,9) -> 9/0, (0,0) -> 0/1, no engine start
    s0 = starts;
    n = cyc;
    push(0, 9, acc);
    push(0, 0, acc);
    wait_rsp(c, d, e);
    chk("z1_latency", c - n, 3);
    chk("z1_data", d, 9);
    chk("z1_err", e, 0);
    wait_rsp(c, d, e);
    chk("z2_data", d, 0);
    chk("z2_err", e, 1);
    chk("z_no_start", starts - s0, 0);

    // ---- engine job (12,18) -> 6, engine done after 5 cycles
    s0 = starts;
    push(12, 18, acc);
    wait_rsp(c, d, e);
    chk("e_data", d, 6);
    chk("e_err", e, 0);
    chk("e_one_start", starts - s0, 1);
    chk("e_done_latency", c - done_cyc, 1);
    chk("e_hold_a", gcd_a, 12);
    chk("e_hold_b", gcd_b, 18);

    // ---- stale done (held high through ISSUE/GUARD) must not be captured
    stale_val = 99;
    stale_done = 1;
    push(35, 14, acc);
    wait_start(c);
    @(posedge clk);          // into GUARD
    @(posedge clk);          // into WAIT
    #1 stale_done = 0;
    wait_rsp(c, d, e);
    chk("stale_data", d, 7);
    chk("stale_err", e, 0);

    // ---- timeout: engine never finishes, response TO cycles after GUARD
    eng_hang = 1;
    push(7, 5, acc);
    wait_start(c);
    wait_rsp(r, d, e);
    chk("to_latency", r - (c + 1), TO);
    chk("to_data", d, 0);
    chk("to_err", e, 1);
    eng_hang = 0;
    @(negedge clk);

    // ---- backpressure: 6 offered, 1 + DEPTH accepted, responses in order
    rsp_ready = 0;
    nacc = 0;
    for (int k = 1; k <= 6; k++) begin
      push(0, W'(k), acc);
      nacc += int'(acc);
    end
    chk("bp_accepted", nacc, 1 + D);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_first_data", rsp_data, 1);
    repeat (3) @(negedge clk);
    chk("bp_stable_valid", rsp_valid, 1);
    chk("bp_stable_data", rsp_data, 1);
    chk("bp_stable_err", rsp_err, 0);
    rsp_ready = 1;
    for (int k = 2; k <= 5; k++) begin
      wait_rsp(c, d, e);
      chk($sformatf("bp_order_%0d", k), d, k);
    end
    repeat (3) @(negedge clk);
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_ready", req_ready, 1);

    // ---- reset mid-job with two queued requests
    eng_hang = 1;
    s0 = starts;
    push(7, 5, acc);
    push(0, 3, acc);
    push(0, 4, acc);
    repeat (4) @(negedge clk);
    chk("mr_in_wait_busy", busy, 1);
    chk("mr_started", starts - s0, 1);
    rst_n = 0;
    #1;
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_req_ready", req_ready, 1);
    chk("mr_gcd_a", gcd_a, 0);
    chk("mr_gcd_b", gcd_b, 0);
    chk("mr_rsp_data", rsp_data, 0);
    chk("mr_rsp_err", rsp_err, 0);
    chk("mr_gcd_start", gcd_start, 0);
    @(negedge clk);
    rst_n = 1;
    eng_hang = 0;
    stale_done = 1;
    nrsp = 0;
    nst = starts;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    stale_done = 0;
    chk("mr_no_response", nrsp, 0);
    chk("mr_no_start", starts - nst, 0);
    chk("mr_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gcd_requester.md
GCD_REQUESTER -- requirements
Module: gcd_requester

Interface
REQ-001 Parameters SHALL be: WIDTH, 16, operand/result width; DEPTH, 4, request queue entries (power of 2); TIMEOUT, 65544, max engine cycles per job.
REQ-002 clk  in  1  single clock, all state on posedge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  request offered; req_ready  out  1  queue not full.
REQ-005 req_a, req_b  in  WIDTH  operand pair, captured when req_valid&&req_ready.
REQ-006 gcd_start  out  1  one-cycle start pulse to subtraction GCD engine.
REQ-007 gcd_a, gcd_b  out  WIDTH  operands to engine, held stable from start until job completes.
REQ-008 gcd_done  in  1  engine level done (sticky until next start); gcd_result  in  WIDTH  engine result.
REQ-009 rsp_valid  out  1  response held; rsp_ready  in  1  consumer accepts.
REQ-010 rsp_data  out  WIDTH  GCD result; rsp_err  out  1  job failed (0,0 operands or timeout).
REQ-011 busy  out  1  high when queue non-empty or FSM not IDLE.

Function
REQ-012 Request queue SHALL be FIFO, DEPTH entries; push on req_valid&&req_ready; simultaneous push/pop when full SHALL NOT be accepted (req_ready = !full).
REQ-013 FSM states SHALL be IDLE, ISSUE, GUARD, WAIT, RESP.
REQ-014 IDLE: if queue non-empty, pop head into operand register, go ISSUE next cycle.
REQ-015 ISSUE with both operands nonzero: assert gcd_start for exactly one cycle, clear timeout counter, go GUARD.
REQ-016 ISSUE with either operand zero: no gcd_start; rsp_data = a|b; rsp_err = (a==0 && b==0); go RESP.
REQ-017 GUARD: one cycle ignoring gcd_done (engine loads A then B); go WAIT.
REQ-018 WAIT: on gcd_done=1 capture gcd_result into rsp_data, rsp_err=0, go RESP; else increment counter.
REQ-019 WAIT: counter reaching TIMEOUT-1 without gcd_done SHALL set rsp_data=0, rsp_err=1, go RESP; gcd_done in the same cycle takes priority.
REQ-020 RESP: rsp_valid=1, rsp_data/rsp_err stable; on rsp_ready go IDLE; pop of next entry no earlier than the following cycle.
REQ-021 Latency SHALL be: zero-operand job rsp_valid 2 cycles after pop; engine job rsp_valid 1 cycle after first qualified gcd_done.
REQ-022 gcd_a/gcd_b SHALL hold the current job operands from ISSUE through RESP.
REQ-023 Timeout counter width SHALL be clog2(TIMEOUT)+1; no wrap.
REQ-024 Queue accepts new requests during any FSM state.

Reset
REQ-025 rst_n low SHALL immediately clear: FIFO pointers/count, FSM to IDLE, counter, gcd_start=0, gcd_a=gcd_b=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0; req_ready=1.
REQ-026 Reset mid-job SHALL discard the job and all queued requests with no response; an engine done pending from before reset is ignored (GUARD rule applies to next job).

Structure
REQ-027 Shared package gcd_pkg SHALL hold the state enum and default WIDTH.
REQ-028 Queue SHALL be a sub-module gcd_req_fifo (width 2*WIDTH, DEPTH entries, full/empty flags).

Verification
REQ-029 Push (12,18), engine model done after 5 cycles with 6 -> rsp_data=6, rsp_err=0, one gcd_start pulse.
REQ-030 Push (0,9) then (0,0) -> responses 9/err0 then 0/err1, no gcd_start.
REQ-031 Push (7,5), engine never asserts done -> rsp_err=1, rsp_data=0 exactly TIMEOUT cycles after GUARD.
REQ-032 rsp_ready=0, push 6 requests -> exactly 1+DEPTH accepted, req_ready low, rsp outputs stable; release -> responses in push order.
REQ-033 Stale gcd_done=1 held high during ISSUE/GUARD -> not captured; result taken from WAIT only.
REQ-034 Assert rst_n low in WAIT with 2 queued -> all outputs reset values, no response after release.
